// File: rtl/cpu_pkg.sv
// Shared core-pipeline types: hazard FSM states, register index width and pipe-register control pair.
package cpu_pkg;

    localparam int unsigned REGW = 3;

    typedef enum logic {
        RUN      = 1'b0,
        FFT_WAIT = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fft_wait_timer.sv
// FFT occupancy watchdog: counts FFT_WAIT cycles and latches a sticky error on timeout.
module fft_wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned FFT_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  hazard_state_e state,
    input  logic          fft_done,
    output logic          timeout_c,
    output logic          fft_err
);

    localparam int unsigned TW = $clog2(FFT_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(FFT_TIMEOUT - 1);

    logic          busy;
    logic [TW-1:0] cnt;

    assign busy      = (state == FFT_WAIT);
    // A completion in the final cycle wins over the timeout.
    assign timeout_c = busy & ~fft_done & (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            fft_err <= 1'b0;
        end else begin
            if (!busy) begin
                cnt <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + TW'(1);
            end
            if (timeout_c) begin
                fft_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use, taken branch, FFT occupancy and memory wait hazards,
// plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REGW        = cpu_pkg::REGW,
    parameter int unsigned FFT_TIMEOUT = 64,
    parameter int unsigned CNTW        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_src_a,
    input  logic            id_src_a_used,
    input  logic [REGW-1:0] id_src_b,
    input  logic            id_src_b_used,
    input  logic            ex_load,
    input  logic [REGW-1:0] ex_wr_reg,
    input  logic            ex_reg_wr_en,
    input  logic            ex_branch_taken,
    input  logic            ex_fft_start,
    input  logic            fft_done,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            pc_stall,
    output logic            fd_stall,
    output logic            fd_flush,
    output logic            de_stall,
    output logic            de_flush,
    output logic            em_stall,
    output logic            em_flush,
    output logic            fft_busy,
    output logic            fft_err,
    output logic [CNTW-1:0] stall_cycles
);

    import cpu_pkg::*;

    hazard_state_e state;
    pipe_ctrl_t    fd_c, de_c, em_c;
    logic          mem_stall_c;
    logic          fft_hold_c;
    logic          load_use_c;
    logic          timeout_c;

    assign mem_stall_c = mem_req & ~mem_ready;
    // fft_done releases the pipe in the same cycle it arrives.
    assign fft_hold_c  = (state == FFT_WAIT) & ~fft_done;
    assign load_use_c  = ex_load & ex_reg_wr_en &
                         ((id_src_a_used & (id_src_a == ex_wr_reg)) |
                          (id_src_b_used & (id_src_b == ex_wr_reg)));

    // Prioritised hazard resolution; only the highest active hazard drives the pipe.
    always_comb begin
        pc_stall = 1'b0;
        fd_c     = '0;
        de_c     = '0;
        em_c     = '0;
        if (rst) begin
            fd_c.flush = 1'b1;
            de_c.flush = 1'b1;
            em_c.flush = 1'b1;
        end else if (mem_stall_c) begin
            pc_stall   = 1'b1;
            fd_c.stall = 1'b1;
            de_c.stall = 1'b1;
            em_c.stall = 1'b1;
        end else if (fft_hold_c) begin
            pc_stall   = 1'b1;
            fd_c.stall = 1'b1;
            de_c.stall = 1'b1;
            em_c.flush = 1'b1;
        end else if (ex_branch_taken) begin
            fd_c.flush = 1'b1;
            de_c.flush = 1'b1;
        end else if (load_use_c) begin
            pc_stall   = 1'b1;
            fd_c.stall = 1'b1;
            de_c.flush = 1'b1;
        end
    end

    assign fd_stall = fd_c.stall;
    assign fd_flush = fd_c.flush;
    assign de_stall = de_c.stall;
    assign de_flush = de_c.flush;
    assign em_stall = em_c.stall;
    assign em_flush = em_c.flush;
    assign fft_busy = fft_hold_c;

    // FFT occupancy FSM; a same-cycle done is a zero-wait completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (ex_fft_start && !mem_stall_c && !fft_done) begin
                        state <= FFT_WAIT;
                    end
                end
                FFT_WAIT: begin
                    if (fft_done || timeout_c) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (pc_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNTW'(1);
        end
    end

    fft_wait_timer #(
        .FFT_TIMEOUT(FFT_TIMEOUT)
    ) u_fft_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .fft_done (fft_done),
        .timeout_c(timeout_c),
        .fft_err  (fft_err)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected controls queued at drive time,
// compared on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REGW = 3;
    localparam int unsigned CNTW = 16;

    // {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, fft_busy, fft_err}
    localparam logic [8:0] IDLE = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] LU   = 9'b1_1_0_0_1_0_0_0_0;
    localparam logic [8:0] BR   = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] FFT  = 9'b1_1_0_1_0_0_1_1_0;
    localparam logic [8:0] MEM  = 9'b1_1_0_1_0_1_0_0_0;
    localparam logic [8:0] RSTV = 9'b0_0_1_0_1_0_1_0_0;
    localparam logic [8:0] ERR  = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        int          id;
        logic [8:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [REGW-1:0] id_src_a, id_src_b, ex_wr_reg;
    logic            id_src_a_used, id_src_b_used;
    logic            ex_load, ex_reg_wr_en, ex_branch_taken, ex_fft_start;
    logic            fft_done, mem_req, mem_ready;
    logic            pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush;
    logic            fft_busy, fft_err;
    logic [CNTW-1:0] stall_cycles;
    logic [8:0]      act;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    pipeline_hazard_ctrl #(
        .REGW       (REGW),
        .FFT_TIMEOUT(8),
        .CNTW       (CNTW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_src_a       (id_src_a),
        .id_src_a_used  (id_src_a_used),
        .id_src_b       (id_src_b),
        .id_src_b_used  (id_src_b_used),
        .ex_load        (ex_load),
        .ex_wr_reg      (ex_wr_reg),
        .ex_reg_wr_en   (ex_reg_wr_en),
        .ex_branch_taken(ex_branch_taken),
        .ex_fft_start   (ex_fft_start),
        .fft_done       (fft_done),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_stall       (pc_stall),
        .fd_stall       (fd_stall),
        .fd_flush       (fd_flush),
        .de_stall       (de_stall),
        .de_flush       (de_flush),
        .em_stall       (em_stall),
        .em_flush       (em_flush),
        .fft_busy       (fft_busy),
        .fft_err        (fft_err),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    assign act = {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush,
                  fft_busy, fft_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drain one expected entry per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("step%0d_ctl", e.id), 32'(act), 32'(e.ctl));
            check($sformatf("step%0d_cnt", e.id), 32'(stall_cycles), 32'(e.cnt));
        end
    end

    task automatic clear_in();
        id_src_a = '0; id_src_a_used = 1'b0;
        id_src_b = '0; id_src_b_used = 1'b0;
        ex_load = 1'b0; ex_wr_reg = '0; ex_reg_wr_en = 1'b0;
        ex_branch_taken = 1'b0; ex_fft_start = 1'b0; fft_done = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic set_load_use(input logic [REGW-1:0] rd, input logic use_a, input logic use_b);
        ex_load = 1'b1; ex_reg_wr_en = 1'b1; ex_wr_reg = rd;
        id_src_a = rd; id_src_a_used = use_a;
        id_src_b = rd; id_src_b_used = use_b;
    endtask

    // Queue the expectation for the cycle whose inputs are now applied, then advance one clock.
    task automatic step(input logic [8:0] ctl, input int cnt);
        exp_t e;
        e.id  = step_id;
        e.ctl = ctl;
        e.cnt = 16'(cnt);
        sb_q.push_back(e);
        step_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        #3;
        check("reset_ctl", 32'(act), 32'(RSTV));
        check("reset_cnt", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(IDLE, 0);

        // Load-use via src B, then src B not used, src A match, and non-writing load.
        set_load_use(3'd3, 1'b0, 1'b1);              step(LU, 0);
        clear_in();                                  step(IDLE, 1);
        set_load_use(3'd3, 1'b0, 1'b0);              step(IDLE, 1);
        clear_in();
        set_load_use(3'd5, 1'b1, 1'b0);              step(LU, 1);
        clear_in();                                  step(IDLE, 2);
        set_load_use(3'd6, 1'b1, 1'b1);
        ex_reg_wr_en = 1'b0;                         step(IDLE, 2);

        // Taken branch overrides a load-use match.
        set_load_use(3'd2, 1'b1, 1'b1);
        ex_branch_taken = 1'b1;                      step(BR, 2);
        clear_in();                                  step(IDLE, 2);

        // FFT issue, done arrives 6 cycles after issue: 5 stalled cycles.
        ex_fft_start = 1'b1;                         step(IDLE, 2);
        clear_in();
        for (int i = 0; i < 5; i++) step(FFT, 2 + i);
        fft_done = 1'b1;                             step(IDLE, 7);
        clear_in();                                  step(IDLE, 7);
        fft_done = 1'b1;                             step(IDLE, 7);
        ex_fft_start = 1'b1;                         step(IDLE, 7);
        clear_in();                                  step(IDLE, 7);

        // Memory wait freezes a coincident taken branch, which acts once memory is ready.
        ex_branch_taken = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(MEM, 7 + i);
        mem_ready = 1'b1;                            step(BR, 10);
        clear_in();
        mem_req = 1'b1;                              step(IDLE, 10);
        clear_in();

        // Timeout: 8 busy cycles then RUN with sticky error.
        ex_fft_start = 1'b1;                         step(IDLE, 10);
        clear_in();
        for (int i = 0; i < 8; i++) step(FFT, 10 + i);
        step(IDLE | ERR, 18);
        step(IDLE | ERR, 18);

        // Reset asserted asynchronously in the second FFT_WAIT cycle.
        ex_fft_start = 1'b1;                         step(IDLE | ERR, 18);
        clear_in();                                  step(FFT | ERR, 18);
        check("fft_cycle2_busy", 32'(fft_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctl", 32'(act), 32'(RSTV));
        check("async_rst_cnt", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(IDLE, 0);
        set_load_use(3'd1, 1'b1, 1'b0);              step(LU, 0);
        clear_in();                                  step(IDLE, 1);

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
